// File: rtl/board_io_pkg.sv
// Shared register offsets, STAT bit positions and the seven-segment decoder
// for the board I/O bridge.
package board_io_pkg;

  localparam int unsigned OFF_LED   = 0;
  localparam int unsigned OFF_HEXLO = 1;
  localparam int unsigned OFF_HEXHI = 2;
  localparam int unsigned OFF_SWREG = 3;
  localparam int unsigned OFF_TIMER = 4;
  localparam int unsigned OFF_STAT  = 5;

  localparam int unsigned STAT_SW_CHG   = 0;
  localparam int unsigned STAT_TMR_WRAP = 1;

  // Segments are {dp,g,f,e,d,c,b,a}, active-low, decimal point kept dark.
  function automatic logic [7:0] seg7_decode(input logic [3:0] val);
    logic [7:0] seg;
    case (val)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/board_io_if.sv
// CPU-side I/O window bus: the core drives select/strobe/address/data,
// the peripheral answers with combinational read data.
interface board_io_if #(
  parameter int ADDR_W = 4
) ();
  logic              io_sel;
  logic              io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [15:0]       io_wdata;
  logic [15:0]       io_rdata;

  modport master (output io_sel, output io_we, output io_addr, output io_wdata, input io_rdata);
  modport slave  (input io_sel, input io_we, input io_addr, input io_wdata, output io_rdata);
endinterface

// File: rtl/board_io_sw_debouncer.sv
// Two-flop synchronizer plus whole-vector debounce for the board switches;
// emits the accepted value and a one-cycle pulse when it changes.
module sw_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int W               = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] sw_raw,
  output logic [W-1:0] stable,
  output logic         change
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [W-1:0]  cand_q, cand_d, stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Acceptance happens on the cycle the count reaches its maximum, so the
  // synchronized value has been sampled DEBOUNCE_CYCLES times in a row.
  always_comb begin
    sync1_d  = sw_raw;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    change   = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_MAX && cand_q != stable_q) begin
        stable_d = cand_q;
        change   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/board_io_bridge.sv
// Memory-mapped board I/O: LED/HEX registers, debounced switches, STAT (W1C)
// and an optional prescaled timer enabled by BOARD_IO_TIMER_EN.
module board_io_bridge
  import board_io_pkg::*;
#(
  parameter int ADDR_W          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PRESCALE        = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  board_io_if.slave  bus,
  input  logic [9:0] SW,
  output logic [9:0] LEDS,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5
);
  logic             wr_en;
  logic [9:0]       led_q, led_d;
  logic [15:0]      hexlo_q, hexlo_d;
  logic [7:0]       hexhi_q, hexhi_d;
  logic [1:0]       stat_q, stat_d;
  logic [5:0][7:0]  hex_q, hex_d;
  logic [9:0]       sw_stable;
  logic             sw_chg;
  logic             tmr_wrap;
  logic [15:0]      timer_rd;
  logic [15:0]      rdata;

  assign wr_en = bus.io_sel & bus.io_we;

  sw_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .W(10)) u_sw_debouncer (
    .CLK    (CLK),
    .RST    (RST),
    .sw_raw (SW),
    .stable (sw_stable),
    .change (sw_chg)
  );

`ifdef BOARD_IO_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   timer_q, timer_d;
  logic          wr_timer;

  assign wr_timer = wr_en && (bus.io_addr == ADDR_W'(OFF_TIMER));

  // A bus write beats a coincident tick, which also suppresses the wrap flag.
  always_comb begin
    presc_d  = presc_q + 1'b1;
    timer_d  = timer_q;
    tmr_wrap = 1'b0;
    if (wr_timer) begin
      presc_d = '0;
      timer_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d  = '0;
      timer_d  = timer_q + 16'd1;
      tmr_wrap = (timer_q == 16'hFFFF);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      timer_q <= '0;
    end else begin
      presc_q <= presc_d;
      timer_q <= timer_d;
    end
  end

  assign timer_rd = timer_q;
`else
  assign tmr_wrap = 1'b0;
  assign timer_rd = '0;
`endif

  always_comb begin
    led_d   = led_q;
    hexlo_d = hexlo_q;
    hexhi_d = hexhi_q;
    if (wr_en && bus.io_addr == ADDR_W'(OFF_LED))   led_d   = bus.io_wdata[9:0];
    if (wr_en && bus.io_addr == ADDR_W'(OFF_HEXLO)) hexlo_d = bus.io_wdata;
    if (wr_en && bus.io_addr == ADDR_W'(OFF_HEXHI)) hexhi_d = bus.io_wdata[7:0];
    // Hardware sets are OR'ed in after the clear so they win a collision.
    stat_d = stat_q;
    if (wr_en && bus.io_addr == ADDR_W'(OFF_STAT)) stat_d = stat_q & ~bus.io_wdata[1:0];
    stat_d[STAT_SW_CHG]   = stat_d[STAT_SW_CHG] | sw_chg;
    stat_d[STAT_TMR_WRAP] = stat_d[STAT_TMR_WRAP] | tmr_wrap;
    for (int n = 0; n < 4; n++) hex_d[n] = seg7_decode(hexlo_q[4*n +: 4]);
    hex_d[4] = seg7_decode(hexhi_q[3:0]);
    hex_d[5] = seg7_decode(hexhi_q[7:4]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      led_q   <= '0;
      hexlo_q <= '0;
      hexhi_q <= '0;
      stat_q  <= '0;
      hex_q   <= {6{8'hC0}};
    end else begin
      led_q   <= led_d;
      hexlo_q <= hexlo_d;
      hexhi_q <= hexhi_d;
      stat_q  <= stat_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.io_sel) begin
      case (bus.io_addr)
        ADDR_W'(OFF_LED):   rdata = {6'b0, led_q};
        ADDR_W'(OFF_HEXLO): rdata = hexlo_q;
        ADDR_W'(OFF_HEXHI): rdata = {8'b0, hexhi_q};
        ADDR_W'(OFF_SWREG): rdata = {6'b0, sw_stable};
        ADDR_W'(OFF_TIMER): rdata = timer_rd;
        ADDR_W'(OFF_STAT):  rdata = {14'b0, stat_q};
        default:            rdata = '0;
      endcase
    end
  end

  assign bus.io_rdata = rdata;
  assign LEDS = led_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_board_io_bridge.sv
// Directed bench for board_io_bridge with DEBOUNCE_CYCLES=4, PRESCALE=3;
// timer checks depend on whether BOARD_IO_TIMER_EN is defined.
module tb_board_io_bridge;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] SW  = 10'h000;
  logic [9:0] LEDS;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [47:0] hex_bus;
  logic [47:0] hex_exp;
  logic [15:0] rd;
  int pass_cnt  = 0;
  int total_cnt = 0;

  board_io_if #(.ADDR_W(4)) bus ();

  board_io_bridge #(.ADDR_W(4), .DEBOUNCE_CYCLES(4), .PRESCALE(3)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .bus  (bus),
    .SW   (SW),
    .LEDS (LEDS),
    .HEX0 (HEX0),
    .HEX1 (HEX1),
    .HEX2 (HEX2),
    .HEX3 (HEX3),
    .HEX4 (HEX4),
    .HEX5 (HEX5)
  );

  assign hex_bus = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    bus.io_sel = 1'b1; bus.io_we = 1'b1; bus.io_addr = a; bus.io_wdata = d;
    @(posedge CLK);
    #1;
    bus.io_sel = 1'b0; bus.io_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
    bus.io_sel = 1'b1; bus.io_we = 1'b0; bus.io_addr = a;
    #1;
    d = bus.io_rdata;
    bus.io_sel = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #12;
    RST = 1'b0;
    tick(1);
    bus_write(4'd0, 16'h02AA);
    bus_write(4'd1, 16'h0008);
    tick(1);
    total_cnt++; if (LEDS !== 10'h2AA) $display("FAIL pre_reset_leds: got %h want %h", LEDS, 10'h2AA); else pass_cnt++;
    total_cnt++; if (HEX0 !== 8'h80) $display("FAIL pre_reset_hex0: got %h want %h", HEX0, 8'h80); else pass_cnt++;
    #2;
    RST = 1'b1;
    #1;
    total_cnt++; if (LEDS !== 10'h000) $display("FAIL reset_leds: got %h want %h", LEDS, 10'h000); else pass_cnt++;
    total_cnt++; if (hex_bus !== {6{8'hC0}}) $display("FAIL reset_hex: got %h want %h", hex_bus, {6{8'hC0}}); else pass_cnt++;
    bus_read(4'd0, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL reset_rdata: got %h want %h", rd, 16'h0000); else pass_cnt++;
    tick(1);
    RST = 1'b0;
    tick(1);
  endtask

  task automatic test_display();
    bus_write(4'd0, 16'hFFFF);
    bus_write(4'd1, 16'h1A3F);
    bus_write(4'd2, 16'h00B2);
    total_cnt++; if (HEX4 !== 8'hC0) $display("FAIL hex4_lag: got %h want %h", HEX4, 8'hC0); else pass_cnt++;
    total_cnt++; if (HEX0 !== 8'h8E) $display("FAIL hex0_early: got %h want %h", HEX0, 8'h8E); else pass_cnt++;
    tick(1);
    total_cnt++; if (LEDS !== 10'h3FF) $display("FAIL leds: got %h want %h", LEDS, 10'h3FF); else pass_cnt++;
    hex_exp = {8'h83, 8'hA4, 8'hF9, 8'h88, 8'hB0, 8'h8E};
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (hex_bus[8*i +: 8] !== hex_exp[8*i +: 8])
        $display("FAIL hex%0d: got %h want %h", i, hex_bus[8*i +: 8], hex_exp[8*i +: 8]);
      else pass_cnt++;
    end
    bus_read(4'd0, rd);
    total_cnt++; if (rd !== 16'h03FF) $display("FAIL led_rd: got %h want %h", rd, 16'h03FF); else pass_cnt++;
    bus_read(4'd1, rd);
    total_cnt++; if (rd !== 16'h1A3F) $display("FAIL hexlo_rd: got %h want %h", rd, 16'h1A3F); else pass_cnt++;
    bus_read(4'd2, rd);
    total_cnt++; if (rd !== 16'h00B2) $display("FAIL hexhi_rd: got %h want %h", rd, 16'h00B2); else pass_cnt++;
  endtask

  task automatic test_switch();
    SW = 10'h155;
    tick(5);
    bus_read(4'd3, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL sw_early: got %h want %h", rd, 16'h0000); else pass_cnt++;
    tick(1);
    bus_read(4'd3, rd);
    total_cnt++; if (rd !== 16'h0155) $display("FAIL sw_accept: got %h want %h", rd, 16'h0155); else pass_cnt++;
    bus_read(4'd5, rd);
    total_cnt++; if (rd !== 16'h0001) $display("FAIL stat_swchg: got %h want %h", rd, 16'h0001); else pass_cnt++;
    bus_write(4'd5, 16'h0001);
    bus_read(4'd5, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL stat_w1c: got %h want %h", rd, 16'h0000); else pass_cnt++;
    SW = 10'h000;
    tick(2);
    SW = 10'h155;
    tick(10);
    bus_read(4'd3, rd);
    total_cnt++; if (rd !== 16'h0155) $display("FAIL sw_glitch: got %h want %h", rd, 16'h0155); else pass_cnt++;
    bus_read(4'd5, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL stat_glitch: got %h want %h", rd, 16'h0000); else pass_cnt++;
  endtask

  task automatic test_unmapped();
    for (int a = 6; a < 16; a++) bus_write(4'(a), 16'hFFFF);
    for (int a = 6; a < 16; a++) begin
      bus_read(4'(a), rd);
      total_cnt++; if (rd !== 16'h0000) $display("FAIL unmapped_%0d: got %h want %h", a, rd, 16'h0000); else pass_cnt++;
    end
    bus_read(4'd1, rd);
    total_cnt++; if (rd !== 16'h1A3F) $display("FAIL unmapped_side: got %h want %h", rd, 16'h1A3F); else pass_cnt++;
  endtask

  task automatic test_no_sel();
    bus.io_sel = 1'b0; bus.io_we = 1'b1; bus.io_addr = 4'd0; bus.io_wdata = 16'h0000;
    #1;
    total_cnt++; if (bus.io_rdata !== 16'h0000) $display("FAIL nosel_rdata: got %h want %h", bus.io_rdata, 16'h0000); else pass_cnt++;
    tick(1);
    bus.io_addr = 4'd1;
    tick(1);
    bus.io_we = 1'b0;
    total_cnt++; if (LEDS !== 10'h3FF) $display("FAIL nosel_leds: got %h want %h", LEDS, 10'h3FF); else pass_cnt++;
    bus_read(4'd1, rd);
    total_cnt++; if (rd !== 16'h1A3F) $display("FAIL nosel_hexlo: got %h want %h", rd, 16'h1A3F); else pass_cnt++;
  endtask

`ifdef BOARD_IO_TIMER_EN
  task automatic preload(input logic [15:0] t, input logic [1:0] p);
    force dut.timer_q = t;
    force dut.presc_q = p;
    #1;
    release dut.timer_q;
    release dut.presc_q;
  endtask

  task automatic test_timer();
    SW  = 10'h000;
    RST = 1'b1;
    #2;
    RST = 1'b0;
    tick(9);
    bus_read(4'd4, rd);
    total_cnt++; if (rd !== 16'd3) $display("FAIL timer_9cyc: got %h want %h", rd, 16'd3); else pass_cnt++;
    preload(16'hFFFF, 2'd0);
    tick(2);
    bus_read(4'd4, rd);
    total_cnt++; if (rd !== 16'hFFFF) $display("FAIL timer_prewrap: got %h want %h", rd, 16'hFFFF); else pass_cnt++;
    bus_read(4'd5, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL stat_prewrap: got %h want %h", rd, 16'h0000); else pass_cnt++;
    tick(1);
    bus_read(4'd4, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL timer_wrap: got %h want %h", rd, 16'h0000); else pass_cnt++;
    bus_read(4'd5, rd);
    total_cnt++; if (rd !== 16'h0002) $display("FAIL stat_wrap: got %h want %h", rd, 16'h0002); else pass_cnt++;
    preload(16'hFFFF, 2'd2);
    bus_write(4'd5, 16'h0002);
    bus_read(4'd5, rd);
    total_cnt++; if (rd !== 16'h0002) $display("FAIL stat_set_wins: got %h want %h", rd, 16'h0002); else pass_cnt++;
    bus_write(4'd5, 16'h0002);
    bus_read(4'd5, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL stat_wrap_clr: got %h want %h", rd, 16'h0000); else pass_cnt++;
    preload(16'hFFFF, 2'd2);
    bus_write(4'd4, 16'h1234);
    bus_read(4'd4, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL timer_wr_wins: got %h want %h", rd, 16'h0000); else pass_cnt++;
    bus_read(4'd5, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL stat_wr_nowrap: got %h want %h", rd, 16'h0000); else pass_cnt++;
    tick(2);
    bus_read(4'd4, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL timer_presc_clr: got %h want %h", rd, 16'h0000); else pass_cnt++;
    tick(1);
    bus_read(4'd4, rd);
    total_cnt++; if (rd !== 16'h0001) $display("FAIL timer_restart: got %h want %h", rd, 16'h0001); else pass_cnt++;
  endtask
`else
  task automatic test_timer();
    bus_write(4'd4, 16'hFFFF);
    tick(10);
    bus_read(4'd4, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL timer_off_rd: got %h want %h", rd, 16'h0000); else pass_cnt++;
    bus_read(4'd5, rd);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL stat_off_rd: got %h want %h", rd, 16'h0000); else pass_cnt++;
  endtask
`endif

  initial begin
    bus.io_sel   = 1'b0;
    bus.io_we    = 1'b0;
    bus.io_addr  = 4'd0;
    bus.io_wdata = 16'h0000;
    test_reset();
    test_display();
    test_switch();
    test_unmapped();
    test_no_sel();
    test_timer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
